// File: rtl/io_bus_pkg.sv
// Shared types and constants for the two-requester I/O / data-RAM bus arbiter.
// The IO_INPUT_SYNC_EN macro selects synchronized input ports in io_port_regs.
package io_bus_pkg;

    localparam int IO_BIT_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_DBG = 1'b1;

    localparam int NUM_OUT_PORTS = 3;
    localparam int NUM_IN_PORTS  = 2;

    localparam logic [31:0] OFS_OUT0 = 32'h0000_0000;
    localparam logic [31:0] OFS_OUT1 = 32'h0000_0004;
    localparam logic [31:0] OFS_OUT2 = 32'h0000_0008;
    localparam logic [31:0] OFS_IN0  = 32'h0000_0040;
    localparam logic [31:0] OFS_IN1  = 32'h0000_0044;

    // On a tie the requester that did not win last time gets the bus.
    function automatic req_id_t pick_winner(input logic r0, input logic r1, input req_id_t last);
        if (r0 && r1) begin
            return (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (r1) begin
            return REQ_DBG;
        end else begin
            return REQ_CPU;
        end
    endfunction

endpackage

// File: rtl/io_port_regs.sv
// Output port registers, input port capture, I/O read mux and illegal-access decode.
// With IO_INPUT_SYNC_EN defined the input ports pass through a two-flop synchronizer.
module io_port_regs
    import io_bus_pkg::*;
#(
    parameter int IO_BIT = IO_BIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              access,
    input  logic              we,
    input  logic [IO_BIT-1:0] offset,
    input  logic [31:0]       wdata,
    input  logic [31:0]       in_port0,
    input  logic [31:0]       in_port1,
    output logic [31:0]       out_port0,
    output logic [31:0]       out_port1,
    output logic [31:0]       out_port2,
    output logic [31:0]       rd_data,
    output logic              err
);

    logic [31:0] ofs_ext;
    logic [31:0] out_val [NUM_OUT_PORTS];
    logic [31:0] in_raw  [NUM_IN_PORTS];
    logic [31:0] in_val  [NUM_IN_PORTS];

    assign ofs_ext   = {{(32-IO_BIT){1'b0}}, offset};
    assign in_raw[0] = in_port0;
    assign in_raw[1] = in_port1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
            logic [31:0] port_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    port_reg <= '0;
                end else if (access && we && (ofs_ext == OFS_OUT0 + 32'(4 * gi))) begin
                    port_reg <= wdata;
                end
            end
            assign out_val[gi] = port_reg;
        end

`ifdef IO_INPUT_SYNC_EN
        for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in_sync
            logic [31:0] sync1_reg;
            logic [31:0] sync2_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_reg <= '0;
                    sync2_reg <= '0;
                end else begin
                    sync1_reg <= in_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end
            assign in_val[gi] = sync2_reg;
        end
`else
        for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in_direct
            assign in_val[gi] = in_raw[gi];
        end
`endif
    endgenerate

    assign out_port0 = out_val[0];
    assign out_port1 = out_val[1];
    assign out_port2 = out_val[2];

    // Writes always read back as zero; writing an input port is an error.
    always_comb begin
        rd_data = '0;
        err     = 1'b1;
        case (ofs_ext)
            OFS_OUT0: begin rd_data = we ? '0 : out_val[0]; err = 1'b0; end
            OFS_OUT1: begin rd_data = we ? '0 : out_val[1]; err = 1'b0; end
            OFS_OUT2: begin rd_data = we ? '0 : out_val[2]; err = 1'b0; end
            OFS_IN0:  begin rd_data = we ? '0 : in_val[0];  err = we;   end
            OFS_IN1:  begin rd_data = we ? '0 : in_val[1];  err = we;   end
            default:  begin rd_data = '0;                   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-requester arbiter sharing one data RAM port and a small I/O register space.
// Define IO_INPUT_SYNC_EN to synchronize in_port0/1 before they are read.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int IO_BIT = IO_BIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic        bus_err
);

    bus_state_t  state_reg;
    req_id_t     grant_reg;
    req_id_t     last_grant_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        ack0_reg;
    logic        ack1_reg;
    logic        bus_err_reg;

    req_id_t     winner;
    logic        is_io;
    logic        io_access;
    logic [31:0] io_rd_data;
    logic        io_err;

    assign winner    = pick_winner(req0, req1, last_grant_reg);
    assign is_io     = addr_reg[IO_BIT];
    assign io_access = (state_reg == ACCESS) && is_io;

    io_port_regs #(
        .IO_BIT (IO_BIT)
    ) u_port_regs (
        .clock     (clock),
        .reset     (reset),
        .access    (io_access),
        .we        (we_reg),
        .offset    (addr_reg[IO_BIT-1:0]),
        .wdata     (wdata_reg),
        .in_port0  (in_port0),
        .in_port1  (in_port1),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .rd_data   (io_rd_data),
        .err       (io_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= REQ_CPU;
            last_grant_reg <= REQ_DBG;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_reg      <= winner;
                        last_grant_reg <= winner;
                        if (winner == REQ_DBG) begin
                            we_reg    <= we1;
                            addr_reg  <= addr1;
                            wdata_reg <= wdata1;
                        end else begin
                            we_reg    <= we0;
                            addr_reg  <= addr0;
                            wdata_reg <= wdata0;
                        end
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    ack0_reg    <= (grant_reg == REQ_CPU);
                    ack1_reg    <= (grant_reg == REQ_DBG);
                    bus_err_reg <= is_io && io_err;
                    rdata_reg   <= is_io ? io_rd_data : '0;
                    state_reg   <= RESP;
                end
                RESP: begin
                    ack0_reg    <= 1'b0;
                    ack1_reg    <= 1'b0;
                    bus_err_reg <= 1'b0;
                    rdata_reg   <= '0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Decoded from state so an asynchronous reset removes the write strobe at once.
    assign mem_we    = (state_reg == ACCESS) && !is_io && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    // RAM read data arrives during RESP, so it bypasses the response register.
    assign rdata   = ((state_reg == RESP) && !is_io && !we_reg) ? mem_rdata : rdata_reg;
    assign ack0    = ack0_reg;
    assign ack1    = ack1_reg;
    assign bus_err = bus_err_reg;

endmodule
